// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data memory access controller:
// access sizes, FSM states, lane widths and the alignment rule.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_WAIT  = 3'd1,
        LD_RESP  = 3'd2,
        RMW_WAIT = 3'd3,
        RMW_WR   = 3'd4
    } state_e;

    // Halves need an even address; words (size 10 or 11) need a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF && lane[0]) bad = 1'b1;
        if (size[1] && lane != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts and sign/zero-extends a load lane from a
// memory word, and merges a sub-word store into the selected lane of a word.
module mem_lane_unit
    import mem_access_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [1:0]        i_lane,
    input  logic [B-1:0]      i_rdata,
    input  logic [HALF_W-1:0] i_wdata,
    output logic [B-1:0]      o_ld_data,
    output logic [B-1:0]      o_st_data
);
    localparam int SHW = $clog2(B);

    logic [SHW-1:0]    sh;
    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;
    logic [B-1:0]      mask;
    logic [B-1:0]      ins;

    // Little-endian lane shift: lane n occupies bits [8n+7:8n].
    always_comb begin
        sh      = SHW'({i_lane, 3'b000});
        ld_byte = BYTE_W'(i_rdata >> sh);
        ld_half = HALF_W'(i_rdata >> sh);

        case (i_size)
            SZ_BYTE: o_ld_data = {{(B-BYTE_W){~i_unsigned & ld_byte[BYTE_W-1]}}, ld_byte};
            SZ_HALF: o_ld_data = {{(B-HALF_W){~i_unsigned & ld_half[HALF_W-1]}}, ld_half};
            default: o_ld_data = i_rdata;
        endcase

        // Store merge only matters for byte/half; word stores bypass this path.
        if (i_size == SZ_BYTE) begin
            mask = B'({BYTE_W{1'b1}}) << sh;
            ins  = B'(i_wdata[BYTE_W-1:0]) << sh;
        end else begin
            mask = B'({HALF_W{1'b1}}) << sh;
            ins  = B'(i_wdata) << sh;
        end
        o_st_data = (i_rdata & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-only, registered-read data memory.
// Byte/half/word loads with extension, read-modify-write for sub-word stores,
// pipeline stall generation and misalignment flagging.
// Optional debug read port enabled by defining MEM_DEBUG_PORT_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    input  logic [W-1:0] i_addr,
    input  logic [B-1:0] i_wdata,
    output logic [B-1:0] o_rdata,
    output logic         o_stall,
    output logic         o_misaligned,
    output logic         o_dm_read,
    output logic         o_dm_write,
    output logic [W-1:0] o_dm_addr,
    output logic [B-1:0] o_dm_wdata,
`ifdef MEM_DEBUG_PORT_EN
    input  logic         i_dbg_en,
    input  logic [W-1:0] i_dbg_addr,
    output logic [B-1:0] o_dbg_data,
`endif
    input  logic [B-1:0] i_dm_rdata
);
    state_e       state_q, state_d;
    logic [B-1:0] rdata_q, rdata_d;
    logic [B-1:0] wdata_q, wdata_d;
    logic [W-1:0] addr_q, addr_d;
    logic [B-1:0] ld_data, st_data;
    logic         req_any, bad_align;
    logic [W-1:0] req_addr;
`ifdef MEM_DEBUG_PORT_EN
    logic         dbg_pend_q, dbg_pend_d;
    logic [B-1:0] dbg_data_q, dbg_data_d;
    assign o_dbg_data = dbg_data_q;
`endif

    assign req_any   = i_mem_read | i_mem_write;
    assign bad_align = is_misaligned(i_size, i_addr[1:0]);
    assign req_addr  = {i_addr[W-1:2], 2'b00};
    assign o_rdata   = rdata_q;

    mem_lane_unit #(.B(B)) u_lane (
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_lane     (i_addr[1:0]),
        .i_rdata    (i_dm_rdata),
        .i_wdata    (i_wdata[HALF_W-1:0]),
        .o_ld_data  (ld_data),
        .o_st_data  (st_data)
    );

    // Next state and memory handshake; IDLE issues in the same cycle so the
    // pipeline sees the stall before it advances past the request.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_dm_read    = 1'b0;
        o_dm_write   = 1'b0;
        o_dm_addr    = addr_q;
        o_dm_wdata   = wdata_q;
`ifdef MEM_DEBUG_PORT_EN
        dbg_pend_d   = 1'b0;
        dbg_data_d   = dbg_pend_q ? i_dm_rdata : dbg_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (bad_align) begin
                        o_misaligned = 1'b1;
                    end else begin
                        o_dm_addr = req_addr;
                        addr_d    = req_addr;
                        if (i_mem_write && i_size[1]) begin
                            o_dm_write = 1'b1;
                            o_dm_wdata = i_wdata;
                            wdata_d    = i_wdata;
                        end else begin
                            o_dm_read = 1'b1;
                            o_stall   = 1'b1;
                            state_d   = i_mem_write ? RMW_WAIT : LD_WAIT;
                        end
                    end
                end
`ifdef MEM_DEBUG_PORT_EN
                else if (i_dbg_en) begin
                    o_dm_read  = 1'b1;
                    o_dm_addr  = {i_dbg_addr[W-1:2], 2'b00};
                    addr_d     = {i_dbg_addr[W-1:2], 2'b00};
                    dbg_pend_d = 1'b1;
                end
`endif
            end
            LD_WAIT: begin
                o_stall = 1'b1;
                rdata_d = ld_data;
                state_d = LD_RESP;
            end
            LD_RESP: begin
                state_d = IDLE;
            end
            RMW_WAIT: begin
                o_stall = 1'b1;
                wdata_d = st_data;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                o_dm_write = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle must never issue an access or hold the pipeline.
        if (!i_rst_n) begin
            o_stall      = 1'b0;
            o_misaligned = 1'b0;
            o_dm_read    = 1'b0;
            o_dm_write   = 1'b0;
            o_dm_addr    = '0;
            o_dm_wdata   = '0;
        end
    end

    // State and datapath registers with synchronous reset (drops any partial RMW word).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
`ifdef MEM_DEBUG_PORT_EN
            dbg_pend_q <= 1'b0;
            dbg_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
`ifdef MEM_DEBUG_PORT_EN
            dbg_pend_q <= dbg_pend_d;
            dbg_data_q <= dbg_data_d;
`endif
        end
    end

endmodule
